// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, register map
// offsets, STATUS bit positions and default parameter values.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_CLK_DIV    = 434;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int BITS_PER_CHAR  = 8;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_IDLE_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  // Assembles the STATUS register image from the individual flags.
  function automatic logic [7:0] pack_status(input logic full, input logic idle,
                                             input logic ovf);
    logic [7:0] v_status;
    v_status                = 8'h00;
    v_status[STAT_FULL_BIT] = full;
    v_status[STAT_IDLE_BIT] = idle;
    v_status[STAT_OVF_BIT]  = ovf;
    return v_status;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding bytes queued for transmission.
// A push while full is ignored even when a pop happens in the same cycle.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == {CW{1'b0}});
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: bytes written into a FIFO are serialised LSB first on txd.
// Raises a level interrupt when enabled and the transmitter has fully drained.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  input  logic       tx_irq_en,
  input  logic       tx_ovf_clr,
  output logic       txd,
  output logic       tx_full,
  output logic       tx_idle,
  output logic       tx_ovf,
  output logic       tx_irq
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLK_DIV - 1);

  tx_state_e          r_state;
  tx_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_baud;
  logic [CNT_W-1:0]   w_baud_nxt;
  logic [2:0]         r_bit;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               r_txd;
  logic               w_txd_nxt;
  logic               r_ovf;
  logic               w_pop;
  logic               w_tick;
  logic               w_fifo_avail;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [7:0]         w_fifo_rdata;
  logic [FIFO_CW-1:0] w_fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BITS_PER_CHAR)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .wdata (tx_data),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign w_tick       = (r_baud == {CNT_W{1'b0}});
  assign w_fifo_avail = (w_fifo_count != {FIFO_CW{1'b0}});

  // State register together with the bit-timing datapath and the registered line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_baud  <= {CNT_W{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // Next-state logic; a pop is requested whenever a new frame is launched.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_avail) begin
          w_state_nxt = ST_START;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick && (r_bit == 3'd7)) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_tick && w_fifo_avail) begin
          w_state_nxt = ST_START;
          w_pop       = 1'b1;
        end else if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and line level; txd is computed from the next state so it is registered.
  always_comb begin
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    if (w_pop) begin
      w_baud_nxt  = BAUD_RELOAD;
      w_bit_nxt   = 3'd0;
      w_shift_nxt = w_fifo_rdata;
    end else if ((r_state != ST_IDLE) && w_tick) begin
      w_baud_nxt = BAUD_RELOAD;
      if (r_state == ST_DATA) begin
        w_bit_nxt   = r_bit + 3'd1;
        w_shift_nxt = {1'b0, r_shift[7:1]};
      end else begin
        w_bit_nxt = 3'd0;
      end
    end else if (r_state != ST_IDLE) begin
      w_baud_nxt = r_baud - CNT_W'(1);
    end else begin
      w_baud_nxt = r_baud;
    end

    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_shift_nxt[0];
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped write takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (tx_wr && w_fifo_full) begin
      r_ovf <= 1'b1;
    end else if (tx_ovf_clr) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign txd     = r_txd;
  assign tx_full = w_fifo_full;
  assign tx_idle = w_fifo_empty & (r_state == ST_IDLE);
  assign tx_ovf  = r_ovf;
  assign tx_irq  = tx_irq_en & tx_idle;

endmodule
